// File: rtl/fp_addsub_arb.sv
// Two-requester round-robin front end for a shared FP add/sub unit, one op in flight.
// Latency req->done is 3 cycles minimum; a requester waits (req held) until its done pulse.
module fp_addsub_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] op1_0,
  input  logic [31:0] op2_0,
  input  logic [31:0] op1_1,
  input  logic [31:0] op2_1,
  input  logic        mode_0,
  input  logic        mode_1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        ovf,
  output logic        err,
  output logic        add_start,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        mode,
  input  logic [31:0] add_result,
  input  logic        add_done,
  input  logic        add_overflow
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic          gnt_q;
  logic          last_q;
  logic [CW-1:0] cnt_q;
  logic          done0_q, done1_q, add_start_q, ovf_q, err_q, mode_q;
  logic [31:0]   result_q, op1_q, op2_q;
  logic          gnt_d;

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign gnt_d = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      add_start_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q       <= gnt_d;
            last_q      <= gnt_d;
            op1_q       <= gnt_d ? op1_1  : op1_0;
            op2_q       <= gnt_d ? op2_1  : op2_0;
            mode_q      <= gnt_d ? mode_1 : mode_0;
            add_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the final timeout cycle still counts as success.
          if (add_done) begin
            result_q <= add_result;
            ovf_q    <= add_overflow;
            err_q    <= 1'b0;
            done0_q  <= ~gnt_q;
            done1_q  <= gnt_q;
            state_q  <= RESP;
          end else if (cnt_q == CNT_MAX) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b1;
            done0_q  <= ~gnt_q;
            done1_q  <= gnt_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign add_start = add_start_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign mode      = mode_q;

endmodule

// File: doc/fp_addsub_arb.md
FP_ADDSUB_ARB -- requirements
Module: fp_addsub_arb

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles waited for add_done after issue before error response.
REQ-002 clk  in  1  clock, rising edge.
REQ-003 n_rst  in  1  reset, asynchronous, active-low.
REQ-004 req0, req1  in  1 each  requester N wants an operation; level, held until done_N.
REQ-005 op1_0, op2_0, op1_1, op2_1  in  32 each  IEEE-754 single operands per requester.
REQ-006 mode_0, mode_1  in  1 each  add/sub select per requester, forwarded unchanged.
REQ-007 done0, done1  out  1 each  one-cycle completion pulse to requester N.
REQ-008 result  out  32  operation result, valid when done0 or done1 is high.
REQ-009 ovf  out  1  add_overflow captured with result.
REQ-010 err  out  1  timeout flag, valid with done pulse.
REQ-011 add_start  out  1  one-cycle start pulse to FP add/sub unit.
REQ-012 op1, op2  out  32 each; mode  out  1  operands and mode to unit.
REQ-013 add_result  in  32; add_done, add_overflow  in  1 each  unit outputs.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE: no req -> stay; any req -> pick grantee, latch its op1/op2/mode into internal registers, go ISSUE next cycle.
REQ-016 Arbitration round-robin: both requesting -> grant the one not granted last; single requester always granted.
REQ-017 last-grant register reset to 1, so first simultaneous request goes to requester 0.
REQ-018 ISSUE: add_start=1 for exactly this cycle; op1/op2/mode drive latched values; next state WAIT.
REQ-019 op1/op2/mode hold latched values from ISSUE through RESP; requester operand changes after the latch cycle are ignored.
REQ-020 WAIT: add_done high -> capture add_result and add_overflow into result/ovf registers, err=0, go RESP.
REQ-021 add_done ignored in the ISSUE cycle itself; earliest capture is the first WAIT cycle.
REQ-022 WAIT timeout counter 0..TIMEOUT-1, increments per WAIT cycle; reaching TIMEOUT-1 with no add_done -> result=0, ovf=0, err=1, go RESP.
REQ-023 add_done and timeout in the same cycle -> add_done wins, err=0.
REQ-024 RESP: done_N=1 for the granted requester only, one cycle; result/ovf/err held stable from RESP until next capture; next state IDLE.
REQ-025 Minimum latency: req high in cycle N (IDLE) -> add_start in N+1 -> add_done seen in N+2 -> done pulse in N+3.
REQ-026 Request dropped by requester mid-operation -> operation still completes and done pulse still issued.
REQ-027 Back-to-back: req still high in IDLE after RESP -> re-arbitrated as new request; at most one operation in flight.
REQ-028 done0 and done1 never high in the same cycle; add_start never high outside ISSUE.

Reset
REQ-029 n_rst low -> immediately: state IDLE, add_start=0, done0=done1=0, result=0, ovf=0, err=0, op1=op2=0, mode=0, counter=0, last-grant=1.
REQ-030 Reset mid-operation abandons it with no done pulse; later add_done while IDLE and no req is ignored.
REQ-031 First request after reset deassertion is sampled on the first rising edge with n_rst high.

Verification
REQ-032 req0 only, op1_0=0x3FA00000, op2_0=0x3FC00000, mode_0=0, unit model returns 0x40300000 one cycle after start -> add_start one cycle with those operands, done0 pulse 3 cycles after req0, result=0x40300000, err=0.
REQ-033 req0 and req1 asserted same cycle after reset, held -> requester 0 served first, then requester 1; done0 precedes done1; add_start pulses exactly twice.
REQ-034 Unit model never asserts add_done, TIMEOUT=16 -> done pulse after 16 WAIT cycles with err=1, result=0.
REQ-035 n_rst asserted during WAIT -> all outputs 0 same cycle, no done pulse; subsequent req1 served normally.
REQ-036 op1_0 changed to 0xBFA00000 one cycle after latch -> op1 output still 0x3FA00000 through RESP.
REQ-037 Continuous req0 and req1 for 10 operations -> grants strictly alternate, no done0/done1 overlap.
